// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO owning the fetch PC; head valid 2 cycles after issue (1 with FETCH_BYPASS_EN).
// Backpressure: dec_stall holds the head; fetch stops once count + inflight reaches DEPTH.
module fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_data,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     dec_stall,
    output logic                     instr_valid,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam logic [CW:0]       DEPTH_V = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  fetchPc;
    logic [ADDR_W-1:0]  inflightPc;
    logic               inflight;
    logic [PW-1:0]      rdPtr;
    logic [PW-1:0]      wrPtr;
    logic [CW-1:0]      cnt;
    logic [INSTR_W-1:0] instrMem [DEPTH];
    logic [ADDR_W-1:0]  pcMem [DEPTH];

    logic               push;
    logic               pop;
    logic               bypassHit;
    logic               storePush;
    logic               fifoPop;
    logic               fifoValid;
    logic [CW:0]        reserved;

    // Space is reserved at issue time, so a push can never find the FIFO full.
    always_comb begin
        reserved = {1'b0, cnt} + {{CW{1'b0}}, inflight};
        imem_req = !reset && !redirect && (reserved < DEPTH_V);
    end

    assign imem_addr = fetchPc;
    assign count     = cnt;
    assign push      = inflight & !redirect & !reset;
    assign fifoValid = (cnt != '0);

`ifdef FETCH_BYPASS_EN
    assign bypassHit = !fifoValid & push;
`else
    assign bypassHit = 1'b0;
`endif

    always_comb begin
        instr_valid = fifoValid | bypassHit;
        instr       = '0;
        instr_pc    = '0;
        if (fifoValid) begin
            instr    = instrMem[rdPtr];
            instr_pc = pcMem[rdPtr];
        end else if (bypassHit) begin
            instr    = imem_data;
            instr_pc = inflightPc;
        end
    end

    // A bypassed entry popped on arrival never touches storage.
    assign pop       = instr_valid & !dec_stall & !redirect;
    assign fifoPop   = pop & !bypassHit;
    assign storePush = push & !(bypassHit & pop);

    always_ff @(posedge clk) begin
        if (storePush) begin
            instrMem[wrPtr] <= imem_data;
            pcMem[wrPtr]    <= inflightPc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc    <= RESET_PC;
            inflightPc <= '0;
            inflight   <= 1'b0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            cnt        <= '0;
        end else if (redirect) begin
            fetchPc  <= redirect_pc;
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            cnt      <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflightPc <= fetchPc;
                fetchPc    <= fetchPc + STEP_V;
            end
            if (storePush) wrPtr <= wrPtr + PW'(1);
            if (fifoPop)   rdPtr <= rdPtr + PW'(1);
            cnt <= cnt + CW'(storePush) - CW'(fifoPop);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: fixed vector table, hand-built corner sequences and a random run against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [15:0] RPC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        dec_stall;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [2:0]  count;

    fetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(16), .INSTR_W(16), .RESET_PC(RPC), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .dec_stall(dec_stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stored PCs as a queue plus the one outstanding read.
    logic [15:0] mFetch;
    logic [15:0] mInflPc;
    bit          mInfl;
    logic [15:0] mq[$];
    bit          modelOn = 1'b0;

    logic        sReq, sValid;
    logic [15:0] sAddr, sPc, sInstr;
    logic [2:0]  sCount;

    function automatic logic [15:0] fdat(input logic [15:0] a);
        return (a * 16'd3) ^ 16'h9E37;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [15:0] rpc, input bit st);
        bit          eReq, eValid, pop, consumed;
        logic [15:0] ePc;
        reset = r; redirect = rd; redirect_pc = rpc; dec_stall = st;
        #3;
        sReq = imem_req; sAddr = imem_addr; sValid = instr_valid;
        sPc = instr_pc; sInstr = instr; sCount = count;

        eReq   = !r && !rd && (mq.size() + int'(mInfl) < DEPTH);
        eValid = 1'b0;
        ePc    = 16'h0;
        if (mq.size() > 0) begin
            eValid = 1'b1; ePc = mq[0];
        end else if (BYP && mInfl && !rd && !r) begin
            eValid = 1'b1; ePc = mInflPc;
        end

        chk("m_req", 32'(sReq), 32'(eReq));
        if (modelOn) begin
            chk("m_addr", 32'(sAddr), 32'(mFetch));
            chk("m_valid", 32'(sValid), 32'(eValid));
            chk("m_pc", 32'(sPc), 32'(ePc));
            chk("m_instr", 32'(sInstr), eValid ? 32'(fdat(ePc)) : 32'h0);
            chk("m_count", 32'(sCount), 32'(mq.size()));
        end

        if (r) begin
            mFetch = RPC; mInfl = 1'b0; mInflPc = 16'h0; mq.delete(); modelOn = 1'b1;
        end else if (rd) begin
            mFetch = rpc; mInfl = 1'b0; mq.delete();
        end else begin
            pop = eValid && !st;
            consumed = 1'b0;
            if (pop) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else consumed = 1'b1;
            end
            if (mInfl && !consumed) mq.push_back(mInflPc);
            if (eReq) begin
                mInflPc = mFetch;
                mFetch  = mFetch + 16'd4;
            end
            mInfl = eReq;
        end

        @(posedge clk);
        #1;
        imem_data = sReq ? fdat(sAddr) : 16'($urandom);
    endtask

    typedef struct {
        bit          rd;
        logic [15:0] rpc;
        bit          st;
        int          cnt;
        bit          vld;
        logic [15:0] pc;
        bit          req;
        logic [15:0] addr;
    } vec_t;

    vec_t        tbl[17];
    logic [15:0] expPc;
    int          pops;
    bit          found;

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; dec_stall = 1'b0; imem_data = 16'h0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);

        // Reset release, free run, 5-cycle stall fill, drain, then redirect to 0x100.
        tbl[0]  = '{1'b0, 16'h0,   1'b0, 0, 1'b0, 16'h0,   1'b1, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0,   1'b0, 0, 1'b0, 16'h0,   1'b1, 16'h0004};
        tbl[2]  = '{1'b0, 16'h0,   1'b0, 1, 1'b1, 16'h0,   1'b1, 16'h0008};
        tbl[3]  = '{1'b0, 16'h0,   1'b0, 1, 1'b1, 16'h4,   1'b1, 16'h000C};
        tbl[4]  = '{1'b0, 16'h0,   1'b1, 1, 1'b1, 16'h8,   1'b1, 16'h0010};
        tbl[5]  = '{1'b0, 16'h0,   1'b1, 2, 1'b1, 16'h8,   1'b1, 16'h0014};
        tbl[6]  = '{1'b0, 16'h0,   1'b1, 3, 1'b1, 16'h8,   1'b0, 16'h0018};
        tbl[7]  = '{1'b0, 16'h0,   1'b1, 4, 1'b1, 16'h8,   1'b0, 16'h0018};
        tbl[8]  = '{1'b0, 16'h0,   1'b1, 4, 1'b1, 16'h8,   1'b0, 16'h0018};
        tbl[9]  = '{1'b0, 16'h0,   1'b0, 4, 1'b1, 16'h8,   1'b0, 16'h0018};
        tbl[10] = '{1'b0, 16'h0,   1'b0, 3, 1'b1, 16'hC,   1'b1, 16'h0018};
        tbl[11] = '{1'b0, 16'h0,   1'b0, 2, 1'b1, 16'h10,  1'b1, 16'h001C};
        tbl[12] = '{1'b0, 16'h0,   1'b0, 2, 1'b1, 16'h14,  1'b1, 16'h0020};
        tbl[13] = '{1'b1, 16'h100, 1'b0, 2, 1'b1, 16'h18,  1'b0, 16'h0024};
        tbl[14] = '{1'b0, 16'h0,   1'b0, 0, 1'b0, 16'h0,   1'b1, 16'h0100};
        tbl[15] = '{1'b0, 16'h0,   1'b0, 0, 1'b0, 16'h0,   1'b1, 16'h0104};
        tbl[16] = '{1'b0, 16'h0,   1'b0, 1, 1'b1, 16'h100, 1'b1, 16'h0108};

`ifndef FETCH_BYPASS_EN
        for (int i = 0; i < 17; i++) begin
            step(1'b0, tbl[i].rd, tbl[i].rpc, tbl[i].st);
            chk($sformatf("vec%0d_count", i), 32'(sCount), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_valid", i), 32'(sValid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_pc", i), 32'(sPc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d_instr", i), 32'(sInstr), tbl[i].vld ? 32'(fdat(tbl[i].pc)) : 32'h0);
            chk($sformatf("vec%0d_req", i), 32'(sReq), 32'(tbl[i].req));
            chk($sformatf("vec%0d_addr", i), 32'(sAddr), 32'(tbl[i].addr));
        end
`else
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
`endif

        // PC wrap and pointer wrap: pops must run FFFC,0,4,... without gaps.
        step(1'b0, 1'b1, 16'hFFFC, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap_first_addr", 32'(sAddr), 32'h0000FFFC);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap_next_addr", 32'(sAddr), 32'h00000000);
        expPc = 16'hFFFC;
        pops  = 0;
        for (int k = 0; k < 40 && pops < 20; k++) begin
            step(1'b0, 1'b0, 16'h0, (k % 4) == 3);
            if (sValid && (k % 4) != 3) begin
                chk("wrap_pop_order", 32'(sPc), 32'(expPc));
                expPc = expPc + 16'd4;
                pops++;
            end
        end
        chk("wrap_pop_total", 32'(pops), 32'd20);

        // Redirect with a valid head and no stall: nothing popped, count cleared.
        step(1'b0, 1'b1, 16'h0200, 1'b0);
        chk("redir_head_valid", 32'(sValid), 32'd1);
        step(1'b0, 1'b1, 16'h0300, 1'b0);
        chk("redir_count_cleared", 32'(sCount), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            if (sValid) begin
                found = 1'b1;
                chk("redir_last_target", 32'(sPc), 32'h00000300);
            end
        end
        if (!found) chk("redir_valid_timeout", 32'd0, 32'd1);

        // Reset mid-stream with two stored entries and a read in flight.
        step(1'b0, 1'b1, 16'h0400, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mq.size() == 2 && mInfl) found = 1'b1;
            else step(1'b0, 1'b0, 16'h0, 1'b1);
        end
        chk("reach_cnt2_inflight", 32'(found), 32'd1);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("rst_cycle_req", 32'(sReq), 32'd0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("rst_count", 32'(sCount), 32'd0);
        chk("rst_valid", 32'(sValid), 32'd0);
        chk("rst_instr", 32'(sInstr), 32'd0);
        chk("rst_instr_pc", 32'(sPc), 32'd0);
        chk("rst_addr", 32'(sAddr), 32'(RPC));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0, 1'b0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit          r, rd, st;
            logic [15:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 3) * 4))
                                              : (16'($urandom) & 16'hFFFC);
            step(r, rd, rpc, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
